// File: rtl/dip_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dip_pkg : shared pixel constants and window type for the binary pipeline
// Revision: 1.0
// ---------------------------------------------------------------------------
package dip_pkg;

  localparam logic BG_PIX    = 1'b1;
  localparam logic FG_PIX    = 1'b0;
  localparam int   IMG_W_DEF = 640;
  localparam int   IMG_H_DEF = 480;

  // Each row holds three columns: bit [2] is the oldest, bit [0] the newest.
  typedef struct packed {
    logic [2:0] top;
    logic [2:0] mid;
    logic [2:0] bot;
  } win3_t;

endpackage
`default_nettype wire

// File: rtl/line_buf_1b.sv
`default_nettype none
// ---------------------------------------------------------------------------
// line_buf_1b : 1-bit simple dual-port RAM, synchronous read-before-write
// Revision: 1.0
// ---------------------------------------------------------------------------
module line_buf_1b #(
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_data
);

  logic mem [DEPTH];
  logic rd_data_q;

  // Contents are deliberately left unreset; the window logic pads the first rows.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/bin_win3x3_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bin_win3x3_gen : 3x3 binary window generator with background edge padding
// Revision: 1.0
// ---------------------------------------------------------------------------
module bin_win3x3_gen
  import dip_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int CW    = 10,
  parameter int RW    = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  input  logic din_vld,
  input  logic din,
  output logic data_en,
  output logic p11,
  output logic p12,
  output logic p13,
  output logic p21,
  output logic p22,
  output logic p23,
  output logic p31,
  output logic p32,
  output logic p33,
  output logic frame_done
);

  localparam int LB_AW = $clog2(IMG_W);

  logic [CW-1:0] col_cnt_q, col_cnt_d, cur_col;
  logic [RW-1:0] row_cnt_q, row_cnt_d, cur_row;
  logic          s1_vld_q, s1_vld_d;
  logic          s1_pix_q, s1_pix_d;
  logic [CW-1:0] s1_col_q, s1_col_d;
  logic [RW-1:0] s1_row_q, s1_row_d;
  win3_t         win_q, win_d;
  logic          data_en_q, data_en_d;
  logic          frame_done_q, frame_done_d;
  logic          lb0_rd, lb1_rd;

  // A coincident frame_start makes this very pixel the frame origin.
  always_comb begin
    cur_col = frame_start ? '0 : col_cnt_q;
    cur_row = frame_start ? '0 : row_cnt_q;
  end

  always_comb begin
    col_cnt_d = cur_col;
    row_cnt_d = cur_row;
    if (din_vld) begin
      if (cur_col == CW'(IMG_W - 1)) begin
        col_cnt_d = '0;
        row_cnt_d = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
      end else begin
        col_cnt_d = cur_col + 1'b1;
      end
    end
  end

  always_comb begin
    s1_vld_d = din_vld;
    s1_pix_d = din_vld ? din     : s1_pix_q;
    s1_col_d = din_vld ? cur_col : s1_col_q;
    s1_row_d = din_vld ? cur_row : s1_row_q;
  end

  line_buf_1b #(.DEPTH(IMG_W)) u_lb0 (
    .clk     (clk),
    .rd_en   (din_vld),
    .rd_addr (cur_col[LB_AW-1:0]),
    .rd_data (lb0_rd),
    .wr_en   (s1_vld_q),
    .wr_addr (s1_col_q[LB_AW-1:0]),
    .wr_data (s1_pix_q)
  );

  line_buf_1b #(.DEPTH(IMG_W)) u_lb1 (
    .clk     (clk),
    .rd_en   (din_vld),
    .rd_addr (cur_col[LB_AW-1:0]),
    .rd_data (lb1_rd),
    .wr_en   (s1_vld_q),
    .wr_addr (s1_col_q[LB_AW-1:0]),
    .wr_data (lb0_rd)
  );

  // Left columns at col 0/1 and upper rows at row 0/1 would otherwise carry
  // the previous line's tail or the previous frame, so they become background.
  always_comb begin
    win_d = win_q;
    if (s1_vld_q) begin
      win_d.top = {win_q.top[1:0], lb1_rd};
      win_d.mid = {win_q.mid[1:0], lb0_rd};
      win_d.bot = {win_q.bot[1:0], s1_pix_q};
      if (s1_row_q < RW'(2)) begin
        win_d.top[0] = BG_PIX;
      end
      if (s1_row_q == '0) begin
        win_d.mid[0] = BG_PIX;
      end
      if (s1_col_q == '0) begin
        win_d.top[2:1] = {2{BG_PIX}};
        win_d.mid[2:1] = {2{BG_PIX}};
        win_d.bot[2:1] = {2{BG_PIX}};
      end else if (s1_col_q == CW'(1)) begin
        win_d.top[2] = BG_PIX;
        win_d.mid[2] = BG_PIX;
        win_d.bot[2] = BG_PIX;
      end
    end
  end

  always_comb begin
    data_en_d    = s1_vld_q;
    frame_done_d = s1_vld_q && (s1_col_q == CW'(IMG_W - 1))
                            && (s1_row_q == RW'(IMG_H - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      s1_vld_q     <= 1'b0;
      s1_pix_q     <= BG_PIX;
      s1_col_q     <= '0;
      s1_row_q     <= '0;
      win_q        <= {9{BG_PIX}};
      data_en_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      s1_vld_q     <= s1_vld_d;
      s1_pix_q     <= s1_pix_d;
      s1_col_q     <= s1_col_d;
      s1_row_q     <= s1_row_d;
      win_q        <= win_d;
      data_en_q    <= data_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign data_en    = data_en_q;
  assign frame_done = frame_done_q;
  assign {p11, p12, p13} = win_q.top;
  assign {p21, p22, p23} = win_q.mid;
  assign {p31, p32, p33} = win_q.bot;

endmodule
`default_nettype wire
